// File: rtl/sram_arb_pkg.sv
// Shared constants for the two-requester sram-like arbiter.
// Port ids double as the 1-bit tags stored in the completion-order FIFO.
package sram_arb_pkg;
    localparam logic PORT_M0         = 1'b0;
    localparam logic PORT_M1         = 1'b1;
    localparam int   ARB_OUTSTANDING = 4;
endpackage

// File: rtl/sram_arb_tag_fifo.sv
// In-order tag FIFO: one port id per accepted downstream transaction.
// Same-cycle push and pop leave count unchanged; pointers wrap modulo DEPTH.
module sram_arb_tag_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       din,
    input  logic                       pop,
    output logic                       head,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

    logic             mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    // Fullness is judged before any pop this cycle, so a pop never frees a slot early.
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/sram_like_arbiter.sv
// Round-robin arbiter sharing one sram-like downstream port between the CPU
// data port (m0) and the debug/DMA port (m1), with in-order data_ok routing.
module sram_like_arbiter
    import sram_arb_pkg::*;
#(
    parameter int OUTSTANDING = ARB_OUTSTANDING
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        m0_req,
    input  logic        m0_wr,
    input  logic [3:0]  m0_wstrb,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic [31:0] m0_rdata,
    output logic        m0_addr_ok,
    output logic        m0_data_ok,

    input  logic        m1_req,
    input  logic        m1_wr,
    input  logic [3:0]  m1_wstrb,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic [31:0] m1_rdata,
    output logic        m1_addr_ok,
    output logic        m1_data_ok,

    output logic        s_req,
    output logic        s_wr,
    output logic [3:0]  s_wstrb,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    input  logic [31:0] s_rdata,
    input  logic        s_addr_ok,
    input  logic        s_data_ok,

    output logic        err
);
    localparam int PTR_W = $clog2(OUTSTANDING);

    // Handshake: a request transfers in the cycle where s_req and s_addr_ok are
    // both high; the requester holds req and its fields until its addr_ok.
    // Completions arrive on s_data_ok strictly in acceptance order.

    logic             last_grant;
    logic             lock;
    logic             lock_id;
    logic             grant;
    logic             accept;
    logic             pop;
    logic             head;
    logic             full;
    logic             empty;
    logic [PTR_W:0]   count;

    always_comb begin
        grant = PORT_M0;
        if (lock) begin
            grant = lock_id;
        end else if (m0_req && !m1_req) begin
            grant = PORT_M0;
        end else if (m1_req && !m0_req) begin
            grant = PORT_M1;
        end else begin
            grant = ~last_grant;
        end
    end

    assign s_req   = (m0_req | m1_req) & ~full & ~reset;
    assign s_wr    = (grant == PORT_M1) ? m1_wr    : m0_wr;
    assign s_wstrb = (grant == PORT_M1) ? m1_wstrb : m0_wstrb;
    assign s_addr  = (grant == PORT_M1) ? m1_addr  : m0_addr;
    assign s_wdata = (grant == PORT_M1) ? m1_wdata : m0_wdata;

    assign accept  = s_req & s_addr_ok;
    assign pop     = s_data_ok & ~empty & ~reset;

    assign m0_addr_ok = accept & (grant == PORT_M0);
    assign m1_addr_ok = accept & (grant == PORT_M1);
    assign m0_data_ok = pop & (head == PORT_M0);
    assign m1_data_ok = pop & (head == PORT_M1);

    // Read data is broadcast; only data_ok identifies the owner.
    assign m0_rdata = s_rdata;
    assign m1_rdata = s_rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= PORT_M1;
            lock       <= 1'b0;
            lock_id    <= PORT_M0;
            err        <= 1'b0;
        end else begin
            if (accept) begin
                last_grant <= grant;
                lock       <= 1'b0;
            end else if (s_req) begin
                // Presented but not taken: hold this requester until accepted.
                lock    <= 1'b1;
                lock_id <= grant;
            end
            if (s_data_ok && (count == '0)) begin
                err <= 1'b1;
            end
        end
    end

    sram_arb_tag_fifo #(
        .DEPTH (OUTSTANDING)
    ) u_tag_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (accept),
        .din   (grant),
        .pop   (pop),
        .head  (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );
endmodule
